alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: W, 16, data width of ALU result path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 in_valid  input  1  upstream offers an ALU result this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_out  input  W  ALU result value.
REQ-007 in_Z  input  3  ALU flags: bit2 = V (overflow), bit1 = N (msb), bit0 = Z (zero).
REQ-008 in_loads  input  1  when 1, the accepted result's flags update the status register.
REQ-009 out_valid  output  1  buffered result available downstream.
REQ-010 out_ready  input  1  downstream takes the result this cycle.
REQ-011 out_data  output  W  oldest buffered result.
REQ-012 status  output  3  status register {V,N,Z}.
REQ-013 cond_sel  input  3  condition code to evaluate against status.
REQ-014 cond_true  output  1  combinational result of cond_sel applied to status.
REQ-015 ovf_count  output  8  count of accepted results with in_Z[2]=1, saturating.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-017 The stage SHALL buffer results in a 2-entry FIFO; in_ready = (occupancy < 2), registered-state derived, not combinationally dependent on out_ready.
REQ-018 out_valid SHALL equal (occupancy > 0); out_data SHALL be the oldest entry; latency from input transfer to out_valid = 1 cycle when empty.
REQ-019 Simultaneous input and output transfer SHALL leave occupancy unchanged and preserve order; at occupancy 2 only output transfer is possible (in_ready=0).
REQ-020 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 Input offered while in_ready=0 SHALL be ignored (no overwrite, no status/count update).
REQ-022 On input transfer with in_loads=1, status SHALL load in_Z on that edge, independent of FIFO drain; in_loads=0 leaves status unchanged.
REQ-023 cond_sel decode: 000 always 1; 001 EQ = Z; 010 NE = !Z; 011 LT = N^V; 100 LE = (N^V)|Z; 101 GE = !(N^V); 110 GT = !(N^V)&!Z; 111 never 0.
REQ-024 ovf_count SHALL increment by 1 on each input transfer with in_Z[2]=1, regardless of in_loads, and saturate at 255 (no wrap).
REQ-025 FIFO read/write pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 or go below 0.
REQ-026 Unknown-free: all outputs SHALL be driven from reset onward.

Reset
REQ-027 While reset_n=0, asynchronously: occupancy 0, out_valid 0, in_ready 1, out_data 0, status 3'b000, ovf_count 0.
REQ-028 Reset asserted mid-operation SHALL discard buffered entries immediately; no output transfer in the reset cycle.
REQ-029 First transfer is permitted on the first rising edge after reset_n deasserts.

Verification
REQ-030 Reset, then in_out=16'h000B, in_Z=000, in_loads=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h000B, status=000, cond_sel=010 gives cond_true=1.
REQ-031 out_ready=0, push 16'h8000/110 then 16'h7FFF/100 -> in_ready=0 after second push; third push ignored; release out_ready -> outputs 16'h8000 then 16'h7FFF in order; ovf_count=2; status=100.
REQ-032 Push in_Z=001, in_loads=1 -> cond EQ=1, LE=1, GT=0; then push in_Z=010, in_loads=0 -> status stays 001.
REQ-033 status=010 (N=1,V=0) -> LT=1, GE=0; status=110 -> LT=0, GE=1, GT=1.
REQ-034 260 transfers with in_Z[2]=1 -> ovf_count=255, holds.
REQ-035 Occupancy 1, simultaneous push and pop for 10 cycles -> occupancy stays 1, order preserved; assert reset_n=0 mid-stream -> out_valid=0 and status=000 without waiting for clk.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result FIFO with a {V,N,Z} status register,
// condition-code evaluation and a saturating overflow-result counter.
module alu_result_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_out,
    input  logic [2:0]   in_Z,
    input  logic         in_loads,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   status,
    input  logic [2:0]   cond_sel,
    output logic         cond_true,
    output logic [7:0]   ovf_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; in_ready depends only on registered occupancy, never on out_ready.

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic [2:0]   status_q, status_d;
    logic [7:0]   ovf_q, ovf_d;

    logic push;
    logic pop;
    logic flag_n, flag_v, flag_z, lt;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign status    = status_q;
    assign ovf_count = ovf_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;
        ovf_d    = ovf_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && in_loads) begin
            status_d = in_Z;
        end
        // Overflow results are counted whether or not they load the flags.
        if (push && in_Z[2] && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            status_q <= 3'b000;
            ovf_q    <= 8'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_out;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            ovf_q    <= ovf_d;
        end
    end

    assign flag_v = status_q[2];
    assign flag_n = status_q[1];
    assign flag_z = status_q[0];
    assign lt     = flag_n ^ flag_v;

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z;
            3'b011:  cond_true = lt;
            3'b100:  cond_true = lt | flag_z;
            3'b101:  cond_true = ~lt;
            3'b110:  cond_true = ~lt & ~flag_z;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
